// File: rtl/uart_frame_serializer.sv
// rtl/uart_frame_serializer.sv - framed UART packet transmitter: header, payload words, optional XOR checksum
module uart_frame_serializer #(
    parameter int                    DATA_W       = 8,
    parameter int                    N_WORDS      = 6,
    parameter logic [2*DATA_W-1:0]   HEADER       = 16'hAA55,
    parameter int                    CLKS_PER_BIT = 1,
    parameter int                    PARITY       = 0,
    parameter int                    STOP_BITS    = 1,
    parameter int                    CHECKSUM_EN  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_WORDS*DATA_W-1:0]   payload_in,
    input  logic                        start,
    output logic                        tx,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun
);

    localparam int W   = 2 + N_WORDS + CHECKSUM_EN;
    localparam int CW  = $clog2(CLKS_PER_BIT) + 1;
    localparam int WCW = $clog2(W) + 1;
    localparam int WIX = $clog2(W);
    localparam int BW  = $clog2(DATA_W);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE} state_t;

    state_t                      state;
    logic [N_WORDS*DATA_W-1:0]   shadow;
    logic [DATA_W-1:0]           checksum_q;
    logic [DATA_W-1:0]           checksum_in;
    logic [DATA_W-1:0]           cur_word;
    logic [DATA_W-1:0]           next_word;
    logic                        par_bit;
    logic [CW-1:0]               clk_cnt;
    logic [BW-1:0]               bit_idx;
    logic [WCW-1:0]              word_idx;
    logic [WCW-1:0]              word_nxt;
    logic                        bit_end;
    logic [DATA_W-1:0]           words [W];

    function automatic logic parity_of(input logic [DATA_W-1:0] w);
        return (^w) ^ (PARITY == 2);
    endfunction

    // XOR of the incoming payload, captured together with the shadow copy
    always_comb begin
        checksum_in = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            checksum_in = checksum_in ^ payload_in[i*DATA_W +: DATA_W];
        end
    end

    // Packet word table in transmit order, built from the captured payload
    always_comb begin
        words[0] = HEADER[DATA_W-1:0];
        words[1] = HEADER[2*DATA_W-1:DATA_W];
        for (int i = 0; i < N_WORDS; i++) begin
            words[2+i] = shadow[i*DATA_W +: DATA_W];
        end
        if (CHECKSUM_EN != 0) begin
            words[W-1] = checksum_q;
        end
    end

    assign word_nxt  = word_idx + WCW'(1);
    assign next_word = words[word_nxt[WIX-1:0]];
    assign bit_end   = (clk_cnt == CW'(CLKS_PER_BIT - 1));

    // Framing FSM: walks start, data, parity and stop bits for every word
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            shadow     <= '0;
            checksum_q <= '0;
            cur_word   <= '0;
            par_bit    <= 1'b0;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            word_idx   <= '0;
        end else begin
            if (start && busy) begin
                overrun <= 1'b1;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= S_START;
                        tx         <= 1'b0;
                        busy       <= 1'b1;
                        shadow     <= payload_in;
                        checksum_q <= checksum_in;
                        cur_word   <= HEADER[DATA_W-1:0];
                        par_bit    <= parity_of(HEADER[DATA_W-1:0]);
                        clk_cnt    <= '0;
                        bit_idx    <= '0;
                        word_idx   <= '0;
                    end else begin
                        state <= S_IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA;
                        tx      <= cur_word[0];
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == BW'(DATA_W - 1)) begin
                            bit_idx <= '0;
                            if (PARITY != 0) begin
                                state <= S_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx  <= bit_idx + BW'(1);
                            cur_word <= cur_word >> 1;
                            tx       <= cur_word[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        state   <= S_STOP;
                        tx      <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == BW'(STOP_BITS - 1)) begin
                            bit_idx <= '0;
                            if (word_idx == WCW'(W - 1)) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                tx    <= 1'b1;
                            end else begin
                                word_idx <= word_nxt;
                                cur_word <= next_word;
                                par_bit  <= parity_of(next_word);
                                state    <= S_START;
                                tx       <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
